// File: rtl/led_pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : led_pwm_pkg                                                  |
// | Desc    : Shared types and register map for the led_pwm_pio block.    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package led_pwm_pkg;

  // Per-channel output mode. MODE_BLINK becomes "breathe" when the block
  // is built with LED_BREATHE_EN.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } led_mode_e;

  // Word addresses
  localparam int ADDR_CTRL  = 0;
  localparam int ADDR_PRE   = 1;
  localparam int ADDR_BLINK = 2;
  localparam int ADDR_CH0   = 3;

  // CTRL fields
  localparam int CTRL_EN_BIT = 0;

  // CH_CFG fields
  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_MODE_W   = 2;
  localparam int CFG_DUTY_LSB = 8;

endpackage : led_pwm_pkg
`default_nettype wire

// File: rtl/led_pwm_timebase.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : led_pwm_timebase                                             |
// | Desc    : Shared prescaler, PWM slot counter and blink phase for all   |
// |           LED channels. All counters advance only while en_i is high.  |
// |           With LED_BREATHE_EN defined the blink counter is dropped and |
// |           the period_end strobe is exported for the per-channel ramps. |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module led_pwm_timebase
  import led_pwm_pkg::*;
#(
  parameter int PWM_W   = 8,
  parameter int PRE_W   = 16,
  parameter int BLINK_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [PRE_W-1:0]   prescale_i,
`ifdef LED_BREATHE_EN
  output logic               period_end_o,
`else
  input  logic [BLINK_W-1:0] blink_half_i,
  output logic               blink_phase_o,
`endif
  output logic [PWM_W-1:0]   pwm_cnt_o
);

  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [PWM_W-1:0] PWM_ONE = PWM_W'(1);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] pwm_cnt_d;
  logic             w_tick;
  logic             w_period_end;

  // A ">=" compare (not "==") lets a lowered PRESCALE wrap immediately.
  assign w_tick       = en_i && (pre_cnt_q >= prescale_i);
  assign w_period_end = w_tick && (pwm_cnt_q == {PWM_W{1'b1}});
  assign pwm_cnt_o    = pwm_cnt_q;

  // Prescaler and PWM slot counter next-state
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    if (en_i) begin
      pre_cnt_d = w_tick ? '0 : pre_cnt_q + PRE_ONE;
      if (w_tick) begin
        pwm_cnt_d = pwm_cnt_q + PWM_ONE;
      end
    end
  end

  // Prescaler and PWM slot counter state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

`ifdef LED_BREATHE_EN
  assign period_end_o = w_period_end;
`else
  localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_d;
  logic               blink_phase_q;
  logic               blink_phase_d;

  assign blink_phase_o = blink_phase_q;

  // Phase toggles after BLINK_HALF+1 full PWM periods
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (w_period_end) begin
      if (blink_cnt_q >= blink_half_i) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_ONE;
      end
    end
  end

  // Blink counter and phase state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`endif

endmodule : led_pwm_timebase
`default_nettype wire

// File: rtl/led_pwm_pio.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : led_pwm_pio                                                  |
// | Desc    : Avalon-MM LED controller, NUM_CH channels, each off/on/PWM/  |
// |           blink. Compare is registered, then the LED drive is          |
// |           registered, so config changes reach the pins two edges after |
// |           the write edge. Build macro LED_BREATHE_EN turns mode 3 into |
// |           a triangle-ramped "breathe" and register 2 into a read-only  |
// |           view of channel 0's ramp value.                              |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module led_pwm_pio
  import led_pwm_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PWM_W   = 8,
  parameter int PRE_W   = 16,
  parameter int BLINK_W = 8,
  parameter int ADDR_W  = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic [NUM_CH-1:0] led_export
);

  logic              ctrl_en_q;
  logic [PRE_W-1:0]  prescale_q;
  led_mode_e         mode_q [NUM_CH];
  logic [PWM_W-1:0]  duty_q [NUM_CH];

  logic [31:0]       w_addr;
  logic [31:0]       w_rd_val;
  logic [PWM_W-1:0]  w_pwm_cnt;
  logic [NUM_CH-1:0] w_ch_on;
  logic [NUM_CH-1:0] ch_on_q;
  logic [NUM_CH-1:0] led_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q;

`ifdef LED_BREATHE_EN
  localparam logic [PWM_W-1:0] PWM_ONE = PWM_W'(1);
  logic                         w_period_end;
  logic [NUM_CH-1:0][PWM_W-1:0] w_ramp;
`else
  logic [BLINK_W-1:0] blink_half_q;
  logic               w_blink_phase;
`endif

  assign w_addr = 32'(avs_address);

  // Register file writes; unmapped addresses fall through untouched
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ctrl_en_q  <= 1'b0;
      prescale_q <= '0;
`ifdef LED_BREATHE_EN
`else
      blink_half_q <= '0;
`endif
      for (int ch = 0; ch < NUM_CH; ch++) begin
        mode_q[ch] <= MODE_OFF;
        duty_q[ch] <= '0;
      end
    end else if (avs_write) begin
      if (w_addr == 32'(ADDR_CTRL)) begin
        ctrl_en_q <= avs_writedata[CTRL_EN_BIT];
      end
      if (w_addr == 32'(ADDR_PRE)) begin
        prescale_q <= avs_writedata[PRE_W-1:0];
      end
`ifdef LED_BREATHE_EN
`else
      if (w_addr == 32'(ADDR_BLINK)) begin
        blink_half_q <= avs_writedata[BLINK_W-1:0];
      end
`endif
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_addr == 32'(ADDR_CH0 + ch)) begin
          mode_q[ch] <= led_mode_e'(avs_writedata[CFG_MODE_LSB +: CFG_MODE_W]);
          duty_q[ch] <= avs_writedata[CFG_DUTY_LSB +: PWM_W];
        end
      end
    end
  end

  // Readback mux; unused bits and unmapped words read as zero
  always_comb begin
    w_rd_val = '0;
    if (w_addr == 32'(ADDR_CTRL)) begin
      w_rd_val[CTRL_EN_BIT] = ctrl_en_q;
    end
    if (w_addr == 32'(ADDR_PRE)) begin
      w_rd_val[PRE_W-1:0] = prescale_q;
    end
    if (w_addr == 32'(ADDR_BLINK)) begin
`ifdef LED_BREATHE_EN
      w_rd_val[PWM_W-1:0] = w_ramp[0];
`else
      w_rd_val[BLINK_W-1:0] = blink_half_q;
`endif
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w_addr == 32'(ADDR_CH0 + ch)) begin
        w_rd_val[CFG_MODE_LSB +: CFG_MODE_W] = mode_q[ch];
        w_rd_val[CFG_DUTY_LSB +: PWM_W]      = duty_q[ch];
      end
    end
  end

  // Read response: data sampled before any same-cycle write lands
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= avs_read ? w_rd_val : 32'h0;
      rvalid_q <= avs_read;
    end
  end

  led_pwm_timebase #(
    .PWM_W   (PWM_W),
    .PRE_W   (PRE_W),
    .BLINK_W (BLINK_W)
  ) u_timebase (
    .clk_i         (clk_clk),
    .rst_i         (reset_reset),
    .en_i          (ctrl_en_q),
    .prescale_i    (prescale_q),
`ifdef LED_BREATHE_EN
    .period_end_o  (w_period_end),
`else
    .blink_half_i  (blink_half_q),
    .blink_phase_o (w_blink_phase),
`endif
    .pwm_cnt_o     (w_pwm_cnt)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic w_pwm_on;
    logic w_mode3_on;
    logic w_sel;

    assign w_pwm_on = (w_pwm_cnt < duty_q[gi]);

`ifdef LED_BREATHE_EN
    logic [PWM_W-1:0] ramp_q;
    logic             ramp_down_q;

    // Triangle ramp 0 -> duty -> 0, one step per PWM period; idle at 0
    always_ff @(posedge clk_clk) begin
      if (reset_reset || (mode_q[gi] != MODE_BLINK)) begin
        ramp_q      <= '0;
        ramp_down_q <= 1'b0;
      end else if (w_period_end) begin
        if (ramp_down_q) begin
          if (ramp_q == '0) begin
            ramp_down_q <= 1'b0;
          end else begin
            ramp_q <= ramp_q - PWM_ONE;
          end
        end else if (ramp_q >= duty_q[gi]) begin
          ramp_q      <= duty_q[gi];
          ramp_down_q <= 1'b1;
        end else begin
          ramp_q <= ramp_q + PWM_ONE;
        end
      end
    end

    assign w_ramp[gi] = ramp_q;
    assign w_mode3_on = (w_pwm_cnt < ramp_q);
`else
    assign w_mode3_on = w_pwm_on & w_blink_phase;
`endif

    // Mode select for this channel
    always_comb begin
      w_sel = 1'b0;
      case (mode_q[gi])
        MODE_OFF:   w_sel = 1'b0;
        MODE_ON:    w_sel = 1'b1;
        MODE_PWM:   w_sel = w_pwm_on;
        MODE_BLINK: w_sel = w_mode3_on;
        default:    w_sel = 1'b0;
      endcase
    end

    assign w_ch_on[gi] = w_sel;
  end

  // Two-stage output: registered compare, then registered LED drive
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ch_on_q <= '0;
      led_q   <= '0;
    end else begin
      ch_on_q <= ctrl_en_q ? w_ch_on : '0;
      led_q   <= ch_on_q;
    end
  end

  assign led_export        = led_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;

endmodule : led_pwm_pio
`default_nettype wire

// File: tb/tb_led_pwm_pio.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_led_pwm_pio                                               |
// | Desc    : Self-checking bench for led_pwm_pio (default build). A       |
// |           cycle-level reference model tracks the register file and     |
// |           timing counters with plain integers; LED and read responses  |
// |           are compared every cycle, plus directed scenario checks.     |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_led_pwm_pio;

  localparam int NUM_CH  = 4;
  localparam int PWM_W   = 8;
  localparam int PRE_W   = 16;
  localparam int BLINK_W = 8;
  localparam int ADDR_W  = 4;
  localparam int PWM_MAX = (1 << PWM_W) - 1;

  logic              clk;
  logic              reset_reset;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic [NUM_CH-1:0] led_export;

  int n_checks = 0;
  int n_fail   = 0;
  bit lock_en  = 0;

  led_pwm_pio #(
    .NUM_CH  (NUM_CH),
    .PWM_W   (PWM_W),
    .PRE_W   (PRE_W),
    .BLINK_W (BLINK_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk_clk           (clk),
    .reset_reset       (reset_reset),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .led_export        (led_export)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_en, m_prescale, m_blink_half;
  int m_mode [NUM_CH];
  int m_duty [NUM_CH];
  int m_pre, m_pwm, m_bcnt, m_phase;
  int m_stage, m_led, m_rd, m_rdv;

  function automatic int reg_value(int a);
    if (a == 0) return m_en;
    if (a == 1) return m_prescale;
    if (a == 2) return m_blink_half;
    if (a >= 3 && a < 3 + NUM_CH) return m_mode[a-3] + (m_duty[a-3] << 8);
    return 0;
  endfunction

  task automatic model_step();
    int a;
    int tick;
    int pe;
    int st;
    logic [31:0] wd;
    if (reset_reset) begin
      m_en = 0; m_prescale = 0; m_blink_half = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_mode[c] = 0; m_duty[c] = 0; end
      m_pre = 0; m_pwm = 0; m_bcnt = 0; m_phase = 0;
      m_stage = 0; m_led = 0; m_rd = 0; m_rdv = 0;
      return;
    end
    a    = int'(avs_address);
    wd   = avs_writedata;
    tick = (m_en != 0 && m_pre >= m_prescale) ? 1 : 0;
    pe   = (tick != 0 && m_pwm == PWM_MAX) ? 1 : 0;
    st   = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      int on;
      on = 0;
      if (m_en != 0) begin
        case (m_mode[c])
          1: on = 1;
          2: on = (m_pwm < m_duty[c]) ? 1 : 0;
          3: on = (m_pwm < m_duty[c] && m_phase != 0) ? 1 : 0;
          default: on = 0;
        endcase
      end
      if (on != 0) st = st | (1 << c);
    end
    m_led   = m_stage;
    m_stage = st;
    m_rdv   = avs_read ? 1 : 0;
    m_rd    = avs_read ? reg_value(a) : 0;
    if (m_en != 0) begin
      if (tick != 0) begin
        m_pre = 0;
        m_pwm = (m_pwm + 1) % (PWM_MAX + 1);
      end else begin
        m_pre++;
      end
      if (pe != 0) begin
        if (m_bcnt >= m_blink_half) begin
          m_bcnt  = 0;
          m_phase = 1 - m_phase;
        end else begin
          m_bcnt++;
        end
      end
    end
    if (avs_write) begin
      if (a == 0) m_en = int'(wd[0]);
      else if (a == 1) m_prescale = int'(wd[PRE_W-1:0]);
      else if (a == 2) m_blink_half = int'(wd[BLINK_W-1:0]);
      else if (a < 3 + NUM_CH) begin
        m_mode[a-3] = int'(wd[1:0]);
        m_duty[a-3] = int'(wd[8 +: PWM_W]);
      end
    end
  endtask

  // Advance the model on every edge and compare outputs shortly after
  always @(posedge clk) begin
    model_step();
    #2;
    if (lock_en) begin
      check_eq("led", 32'(led_export), 32'(m_led));
      check_eq("rvalid", 32'(avs_readdatavalid), 32'(m_rdv));
      if (m_rdv != 0) check_eq("rdata", avs_readdata, 32'(m_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    avs_address   = ADDR_W'(a);
    avs_writedata = d;
    avs_write     = 1'b1;
    cyc(1);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    avs_address = ADDR_W'(a);
    avs_read    = 1'b1;
    cyc(1);
    avs_read    = 1'b0;
    v           = avs_readdata;
  endtask

  task automatic count_high(input int b, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      cyc(1);
      if (led_export[b]) cnt++;
    end
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    cyc(2);
    reset_reset = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] v;
    int cnt;
    int f0, f1, f2;

    reset_reset   = 1'b1;
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    avs_read      = 1'b0;
    cyc(3);
    reset_reset = 1'b0;
    lock_en     = 1'b1;

    // Reset state
    for (int a = 0; a < 7; a++) begin
      rd(a, v);
      check_eq($sformatf("rst_rd%0d", a), v, 32'h0);
    end
    check_eq("rst_led", 32'(led_export), 32'h0);

    // Mode on: output rises two edges after the CH_CFG write edge
    wr(0, 32'h1);
    wr(3, 32'h1);
    cyc(1);
    check_eq("on_lat1", 32'(led_export), 32'h0);
    cyc(1);
    check_eq("on_lat2", 32'(led_export), 32'h1);

    // PWM duty on channel 1
    wr(3, 32'h0);
    wr(4, 32'h2 | (32'd64 << 8));
    cyc(600);
    count_high(1, 256, cnt);
    check_eq("pwm_duty64", 32'(cnt), 32'd64);
    wr(4, 32'h2);
    cyc(10);
    count_high(1, 256, cnt);
    check_eq("pwm_duty0", 32'(cnt), 32'd0);
    wr(4, 32'h2 | (32'd255 << 8));
    cyc(10);
    count_high(1, 256, cnt);
    check_eq("pwm_duty255", 32'(cnt), 32'd255);

    // Blink on channel 2: phase period 1024 cycles, half of it gated on
    wr(4, 32'h0);
    wr(2, 32'h1);
    wr(5, 32'h3 | (32'd128 << 8));
    cyc(1100);
    count_high(2, 1024, cnt);
    check_eq("blink_cnt", 32'(cnt), 32'd256);

    // Prescaler lowered below the running count
    do_reset();
    wr(3, 32'h2 | (32'd1 << 8));
    wr(4, 32'h2 | (32'd2 << 8));
    wr(5, 32'h2 | (32'd3 << 8));
    wr(1, 32'd9);
    wr(0, 32'h1);
    cyc(7);
    wr(1, 32'd3);
    f0 = -1; f1 = -1; f2 = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (f0 < 0 && !led_export[0]) f0 = k;
      if (f1 < 0 && !led_export[1]) f1 = k;
      if (f2 < 0 && !led_export[2]) f2 = k;
    end
    check_eq("pre_fall0", 32'(f0), 32'd3);
    check_eq("pre_gap1", 32'(f1 - f0), 32'd4);
    check_eq("pre_gap2", 32'(f2 - f1), 32'd4);

    // Unmapped address
    wr(15, 32'hFFFF_FFFF);
    rd(15, v);
    check_eq("unmapped_rd", v, 32'h0);
    rd(1, v);
    check_eq("pre_keep", v, 32'd3);
    rd(0, v);
    check_eq("ctrl_keep", v, 32'd1);

    // Disable during PWM holds counters, re-enable resumes
    wr(3, 32'h2 | (32'd100 << 8));
    wr(1, 32'd0);
    cyc(50);
    wr(0, 32'h0);
    cyc(2);
    check_eq("dis_led", 32'(led_export), 32'h0);
    cyc(37);
    check_eq("dis_hold", 32'(led_export), 32'h0);
    wr(0, 32'h1);
    cyc(300);
    count_high(0, 256, cnt);
    check_eq("reen_duty100", 32'(cnt), 32'd100);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      int op;
      int a;
      op = int'($urandom_range(0, 9));
      a  = int'($urandom_range(0, 15));
      avs_address   = ADDR_W'(a);
      avs_write     = (op < 4);
      avs_read      = (op >= 3 && op < 7);
      avs_writedata = $urandom;
      if (a == 0) avs_writedata = ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0;
      if (a == 1) avs_writedata = 32'($urandom_range(0, 3));
      if (a == 2) avs_writedata = 32'($urandom_range(0, 2));
      reset_reset = ($urandom_range(0, 999) == 0);
      cyc(1);
      avs_write   = 1'b0;
      avs_read    = 1'b0;
      reset_reset = 1'b0;
    end

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_led_pwm_pio
`default_nettype wire
